pwm_multi: RTL

- Multi-channel PWM DAC generator. Next generation of the single-channel PWM block.
- Adds parametrised resolution, channel count and count mode (up / down / center-aligned).
- Double-buffers each channel's duty so updates land glitch-free on a period boundary. Emits a period-start strobe.
- All channels share one counter. Sits between register/control logic and the RC-filtered output pins.

---
 rtl/pwm_multi.sv | 104 ++++++++++
 1 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator sharing one counter (up, down or center-aligned).
// Each channel's duty is double-buffered and takes effect only on a period boundary.
module pwm_multi #(
   parameter int unsigned WIDTH    = 10,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned MODE     = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [CHANNELS*WIDTH-1:0]    duty_in,
   input  logic                         load,
   output logic [CHANNELS-1:0]          pwm_out,
   output logic                         period_start,
   output logic [WIDTH-1:0]             cnt_out
);

   localparam logic [WIDTH-1:0] MAX   = '1;
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0] START = (MODE == 1) ? MAX : '0;

   logic [WIDTH-1:0]    r_cnt;
   logic                r_dir;   // 1 = counting down (center-aligned mode only)
   logic [CHANNELS-1:0] r_pwm;
   logic                r_ps;
   logic [WIDTH-1:0]    r_pending [CHANNELS];
   logic [WIDTH-1:0]    r_active  [CHANNELS];

   logic [WIDTH-1:0]    w_cnt_nxt;
   logic                w_dir_nxt;
   logic                w_boundary;

   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_dir_nxt  = r_dir;
      w_boundary = 1'b0;
      if (MODE == 1) begin
         w_cnt_nxt  = r_cnt - ONE;
         w_boundary = (r_cnt == '0);
      end else if (MODE == 2) begin
         // Direction turns at both extremes, so MAX and 0 appear once per period.
         if (!r_dir) begin
            if (r_cnt == MAX) begin
               w_cnt_nxt = r_cnt - ONE;
               w_dir_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + ONE;
            end
         end else begin
            if (r_cnt == '0) begin
               w_cnt_nxt = r_cnt + ONE;
               w_dir_nxt = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt - ONE;
            end
         end
         w_boundary = r_dir && (r_cnt == ONE);
      end else begin
         w_cnt_nxt  = r_cnt + ONE;
         w_boundary = (r_cnt == MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= START;
         r_dir <= 1'b0;
         r_pwm <= '0;
         r_ps  <= 1'b0;
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            r_pending[k] <= '0;
            r_active[k]  <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (load) begin
               r_pending[k] <= duty_in[k*WIDTH +: WIDTH];
            end
            // While idle the active duty tracks pending so a restart uses the latest load.
            if (!en || w_boundary) begin
               r_active[k] <= r_pending[k];
            end
         end
         if (en) begin
            r_cnt <= w_cnt_nxt;
            r_dir <= w_dir_nxt;
            r_ps  <= w_boundary;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
               r_pwm[k] <= (r_cnt < r_active[k]);
            end
         end else begin
            r_cnt <= START;
            r_dir <= 1'b0;
            r_pwm <= '0;
            r_ps  <= 1'b0;
         end
      end
   end

   assign pwm_out      = r_pwm;
   assign period_start = r_ps;
   assign cnt_out      = r_cnt;

endmodule
